// File: rtl/xbar_pkg.sv
// xbar_pkg: shared definitions for the crossbar burst scheduler.
//   state_e      : scheduler FSM states (IDLE, XFER)
//   XBAR_*       : default NUM_REQ / LEN_WIDTH / AGE_WIDTH
//   xbar_log2()  : ceil(log2(n)) for id widths and tree depth
package xbar_pkg;

  localparam int XBAR_NUM_REQ   = 8;
  localparam int XBAR_LEN_WIDTH = 10;
  localparam int XBAR_AGE_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic int xbar_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/xbar_scheduler_if.sv
// xbar_scheduler_if: request / grant / beat bundle of the scheduler.
//   req_valid, req_len, req_privil, req_dst : per-requester requests (packed)
//   fifo_state                              : destination FIFO full flags
//   gnt, gnt_id, dst_sel, beat_en, done, abort : scheduler outputs
// master = request source (bench / upstream), slave = scheduler.
interface xbar_scheduler_if
  import xbar_pkg::*;
#(
  parameter int NUM_REQ   = XBAR_NUM_REQ,
  parameter int LEN_WIDTH = XBAR_LEN_WIDTH,
  parameter int ID_WIDTH  = xbar_log2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]           req_privil;
  logic [NUM_REQ*ID_WIDTH-1:0]  req_dst;
  logic [NUM_REQ-1:0]           fifo_state;
  logic [NUM_REQ-1:0]           gnt;
  logic [ID_WIDTH-1:0]          gnt_id;
  logic [NUM_REQ-1:0]           dst_sel;
  logic                         beat_en;
  logic                         done;
  logic                         abort;

  modport master (
    output req_valid, req_len, req_privil, req_dst, fifo_state,
    input  gnt, gnt_id, dst_sel, beat_en, done, abort
  );

  modport slave (
    input  req_valid, req_len, req_privil, req_dst, fifo_state,
    output gnt, gnt_id, dst_sel, beat_en, done, abort
  );

endinterface

// File: rtl/xbar_arb_tree.sv
// xbar_arb_tree: log2(NUM_REQ)-level combinational max-select tree.
//   key[i]  : priority key of requester i ({eligible, privileged, len})
//   win_key : key of the overall winner
//   win_id  : index of the overall winner
// Node j of a level compares children 2j (lo) and 2j+1 (hi), so a full
// key tie always propagates the higher index.
module xbar_arb_tree
  import xbar_pkg::*;
#(
  parameter int NUM_REQ = XBAR_NUM_REQ,
  parameter int KW      = XBAR_LEN_WIDTH + 2,
  parameter int IW      = xbar_log2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0][KW-1:0] key,
  output logic [KW-1:0]              win_key,
  output logic [IW-1:0]              win_id
);

  localparam int LVLS = xbar_log2(NUM_REQ);

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = NUM_REQ >> l;
    logic [N-1:0][KW-1:0] k;
    logic [N-1:0][IW-1:0] id;
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_n
        assign k[j]  = key[j];
        assign id[j] = IW'(j);
      end
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_n
        xbar_cmp #(.KW(KW), .IW(IW)) u_cmp (
          .lo_key (g_lvl[l-1].k[2*j]),
          .lo_id  (g_lvl[l-1].id[2*j]),
          .hi_key (g_lvl[l-1].k[2*j+1]),
          .hi_id  (g_lvl[l-1].id[2*j+1]),
          .win_key(k[j]),
          .win_id (id[j])
        );
      end
    end
  end

  assign win_key = g_lvl[LVLS].k[0];
  assign win_id  = g_lvl[LVLS].id[0];

endmodule

// File: rtl/xbar_cmp.sv
// xbar_cmp: two-input max-select on a packed priority key.
//   lo_key/lo_id : candidate with the lower index
//   hi_key/hi_id : candidate with the higher index
//   win_key/win_id : larger key; equal keys resolve to the hi candidate
module xbar_cmp #(
  parameter int KW = 12,
  parameter int IW = 3
) (
  input  logic [KW-1:0] lo_key,
  input  logic [IW-1:0] lo_id,
  input  logic [KW-1:0] hi_key,
  input  logic [IW-1:0] hi_id,
  output logic [KW-1:0] win_key,
  output logic [IW-1:0] win_id
);

  always_comb begin
    win_key = lo_key;
    win_id  = lo_id;
    if (hi_key >= lo_key) begin
      win_key = hi_key;
      win_id  = hi_id;
    end
  end

endmodule

// File: rtl/xbar_scheduler.sv
// xbar_scheduler: picks one requester at a time and streams its burst
// to a destination port, one beat per cycle while the FIFO has room.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : xbar_scheduler_if.slave (requests in; gnt/gnt_id/dst_sel/
//          beat_en/done/abort out)
// Optional: define XBAR_SCHED_AGING_EN to add per-requester saturating
// age counters; a saturated counter makes that requester privileged.
module xbar_scheduler
  import xbar_pkg::*;
#(
  parameter int NUM_REQ   = XBAR_NUM_REQ,
  parameter int LEN_WIDTH = XBAR_LEN_WIDTH,
  parameter int ID_WIDTH  = xbar_log2(NUM_REQ),
  parameter int AGE_WIDTH = XBAR_AGE_WIDTH
) (
  input logic              clk,
  input logic              rst,
  xbar_scheduler_if.slave  bus
);

  localparam int KW = LEN_WIDTH + 2;

  logic [NUM_REQ-1:0]          elig;
  logic [NUM_REQ-1:0]          priv_eff;
  logic [NUM_REQ-1:0][KW-1:0]  key;
  logic [KW-1:0]               win_key;
  logic [ID_WIDTH-1:0]         win_id;
  logic                        win_priv_unused;
  logic                        grant_ev;
  logic                        win_valid;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   gid_q, gid_d;
  logic [ID_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;

  // Key ordering {eligible, privileged, len} gives the whole selection
  // rule as a single unsigned compare.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (bus.req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
      key[i]  = {elig[i], priv_eff[i], bus.req_len[i*LEN_WIDTH +: LEN_WIDTH]};
    end
  end

  xbar_arb_tree #(.NUM_REQ(NUM_REQ), .KW(KW), .IW(ID_WIDTH)) u_tree (
    .key    (key),
    .win_key(win_key),
    .win_id (win_id)
  );

  assign win_priv_unused = win_key[KW-2];

`ifdef XBAR_SCHED_AGING_EN
  logic [NUM_REQ-1:0][AGE_WIDTH-1:0] age_q, age_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) priv_eff[i] = bus.req_privil[i] | (&age_q[i]);
  end

  always_comb begin
    age_d = age_q;
    if (grant_ev) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ID_WIDTH'(i) == win_id)          age_d[i] = '0;
        else if (elig[i] && !(&age_q[i]))    age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  localparam int age_width_unused = AGE_WIDTH;
  assign priv_eff = bus.req_privil;
`endif

  // Outputs are decoded from state only (plus live valid/full), so an
  // asynchronous reset of state_q forces them all low at once.
  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    grant_ev    = 1'b0;
    bus.gnt     = '0;
    bus.gnt_id  = '0;
    bus.dst_sel = '0;
    bus.beat_en = 1'b0;
    bus.done    = 1'b0;
    bus.abort   = 1'b0;
    win_valid   = bus.req_valid[gid_q];
    case (state_q)
      IDLE: begin
        if (win_key[KW-1]) begin
          grant_ev = 1'b1;
          state_d  = XFER;
          gid_d    = win_id;
          rem_d    = win_key[LEN_WIDTH-1:0];
          dst_d    = bus.req_dst[win_id*ID_WIDTH +: ID_WIDTH];
        end
      end
      XFER: begin
        bus.gnt[gid_q] = 1'b1;
        bus.gnt_id     = gid_q;
        // A dropped valid wins over a beat in the same cycle.
        if (!win_valid) begin
          bus.done  = 1'b1;
          bus.abort = 1'b1;
          state_d   = IDLE;
        end else if (!bus.fifo_state[dst_q]) begin
          bus.beat_en        = 1'b1;
          bus.dst_sel[dst_q] = 1'b1;
          rem_d              = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) begin
            bus.done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_xbar_scheduler.sv
// tb_xbar_scheduler: table-driven per-cycle vectors plus hand sequences
// for reset-mid-burst and (with XBAR_SCHED_AGING_EN) aging.
module tb_xbar_scheduler;
  import xbar_pkg::*;

  localparam int N  = 8;
  localparam int LW = 10;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_scheduler_if #(.NUM_REQ(N), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  xbar_scheduler #(.NUM_REQ(N), .LEN_WIDTH(LW), .ID_WIDTH(IW), .AGE_WIDTH(4)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0]    valid;
    logic [N-1:0]    priv;
    logic [N-1:0]    fifo;
    logic [N*LW-1:0] len;
    logic [N*IW-1:0] dst;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gid;
    logic [N-1:0]    dsel;
    logic            beat;
    logic            done;
    logic            abort;
  } vec_t;

  vec_t vecs[$];
  int   lens[N];
  int   dsts[N];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] valid, input logic [N-1:0] priv, input logic [N-1:0] fifo,
                     input logic [N-1:0] gnt, input int gid, input logic [N-1:0] dsel,
                     input logic beat, input logic done, input logic abort);
    vec_t v;
    v.valid = valid; v.priv = priv; v.fifo = fifo;
    for (int i = 0; i < N; i++) begin
      v.len[i*LW +: LW] = LW'(lens[i]);
      v.dst[i*IW +: IW] = IW'(dsts[i]);
    end
    v.gnt = gnt; v.gid = IW'(gid); v.dsel = dsel;
    v.beat = beat; v.done = done; v.abort = abort;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [N-1:0] valid, input logic [N-1:0] priv, input logic [N-1:0] fifo);
    bus.req_valid  = valid;
    bus.req_privil = priv;
    bus.fifo_state = fifo;
    for (int i = 0; i < N; i++) begin
      bus.req_len[i*LW +: LW] = LW'(lens[i]);
      bus.req_dst[i*IW +: IW] = IW'(dsts[i]);
    end
  endtask

  task automatic clear_lens();
    for (int i = 0; i < N; i++) begin
      lens[i] = 0;
      dsts[i] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_lens();
    drive('0, '0, '0);

    // Two equal len-4 requests: higher index first, then requester 0.
    lens[0] = 4; lens[2] = 4; dsts[0] = 1; dsts[2] = 3;
    add(8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(8'h05, 8'h00, 8'h00, 8'h04, 2, 8'h08, 1, (b == 3), 0);
    add(8'h01, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(8'h01, 8'h00, 8'h00, 8'h01, 0, 8'h02, 1, (b == 3), 0);
    add(8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // Zero-length requests are ignored.
    lens[0] = 0; lens[2] = 0;
    add(8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // Privileged short burst beats long one; changes after grant ignored.
    clear_lens();
    lens[1] = 100; lens[6] = 3; dsts[6] = 2;
    add(8'h42, 8'h40, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(8'h42, 8'h40, 8'h00, 8'h40, 6, 8'h04, 1, 0, 0);
    dsts[6] = 7; lens[6] = 9;
    add(8'h42, 8'h00, 8'h00, 8'h40, 6, 8'h04, 1, 0, 0);
    add(8'h42, 8'h00, 8'h00, 8'h40, 6, 8'h04, 1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // Full destination stalls for two cycles; other ports' full flags ignored.
    clear_lens();
    lens[3] = 3; dsts[3] = 5;
    add(8'h08, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(8'h08, 8'h00, 8'h10, 8'h08, 3, 8'h20, 1, 0, 0);
    add(8'h08, 8'h00, 8'h20, 8'h08, 3, 8'h00, 0, 0, 0);
    add(8'h08, 8'h00, 8'h20, 8'h08, 3, 8'h00, 0, 0, 0);
    add(8'h08, 8'h00, 8'h00, 8'h08, 3, 8'h20, 1, 0, 0);
    add(8'h08, 8'h00, 8'h00, 8'h08, 3, 8'h20, 1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // Valid drops after 2 of 6 beats: abort wins over a possible beat.
    clear_lens();
    lens[5] = 6; dsts[5] = 0;
    add(8'h20, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(8'h20, 8'h00, 8'h00, 8'h20, 5, 8'h01, 1, 0, 0);
    add(8'h20, 8'h00, 8'h00, 8'h20, 5, 8'h01, 1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 8'h20, 5, 8'h00, 0, 1, 1);
    add(8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // Single-beat burst.
    clear_lens();
    lens[4] = 1; dsts[4] = 6;
    add(8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(8'h10, 8'h00, 8'h00, 8'h10, 4, 8'h40, 1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", bus.gnt, 0);
    chk("reset gnt_id", bus.gnt_id, 0);
    chk("reset beat_en", bus.beat_en, 0);
    chk("reset done", bus.done, 0);
    chk("reset dst_sel", bus.dst_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      bus.req_valid  = vecs[k].valid;
      bus.req_privil = vecs[k].priv;
      bus.fifo_state = vecs[k].fifo;
      bus.req_len    = vecs[k].len;
      bus.req_dst    = vecs[k].dst;
      @(negedge clk);
      chk($sformatf("v%0d gnt", k), bus.gnt, vecs[k].gnt);
      chk($sformatf("v%0d gnt_id", k), bus.gnt_id, vecs[k].gid);
      chk($sformatf("v%0d dst_sel", k), bus.dst_sel, vecs[k].dsel);
      chk($sformatf("v%0d beat_en", k), bus.beat_en, vecs[k].beat);
      chk($sformatf("v%0d done", k), bus.done, vecs[k].done);
      chk($sformatf("v%0d abort", k), bus.abort, vecs[k].abort);
      @(posedge clk); #1;
    end

    // Reset asserted between edges in the middle of a burst.
    clear_lens();
    lens[1] = 5; dsts[1] = 4;
    drive(8'h02, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst seq idle gnt", bus.gnt, 0);
    @(posedge clk); #1;
    chk("rst seq gnt", bus.gnt, 8'h02);
    chk("rst seq beat", bus.beat_en, 1);
    chk("rst seq dst_sel", bus.dst_sel, 8'h10);
    #2 rst = 1'b1;
    #1;
    chk("rst async gnt", bus.gnt, 0);
    chk("rst async beat", bus.beat_en, 0);
    chk("rst async dst_sel", bus.dst_sel, 0);
    chk("rst async done", bus.done, 0);
    @(posedge clk); #1;
    chk("rst held gnt", bus.gnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst release done", bus.done, 0);
    chk("rst release gnt", bus.gnt, 0);
    @(posedge clk); #1;
    chk("first arb gnt", bus.gnt, 8'h02);
    chk("first arb gnt_id", bus.gnt_id, 1);
    drive(8'h00, 8'h00, 8'h00);
    #1;
    chk("rst seq abort", bus.abort, 1);
    @(posedge clk); #1;
    chk("rst seq back idle", bus.gnt, 0);

`ifdef XBAR_SCHED_AGING_EN
    begin
      int          losses;
      int          cyc;
      bit          won;
      logic [N-1:0] prev;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_lens();
      lens[0] = 1; lens[7] = 50;
      drive(8'h81, 8'h00, 8'h00);
      losses = 0; cyc = 0; won = 0; prev = '0;
      while (!won && cyc < 5000) begin
        @(negedge clk);
        if (bus.gnt != 0 && prev == 0) begin
          if (bus.gnt_id == 0) won = 1;
          else losses++;
        end
        prev = bus.gnt;
        cyc++;
      end
      chk("aging won", won, 1);
      chk("aging losses in 1..16", (losses >= 1 && losses <= 16), 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
